// File: rtl/imem_resp_pkg.sv
// Shared types for the instruction-memory responder.
package rvga_types;

    typedef logic [31:0] rvga_word;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2
    } imem_resp_state_e;

    localparam rvga_word RVGA_NOP = 32'h0000_0013;

endpackage

// File: rtl/imem_resp_if.sv
// Backing-memory request/response bus between imem_resp (master) and system memory (slave).
interface imem_resp_if;
    import rvga_types::*;

    logic     mem_req_v_o;
    rvga_word mem_addr_o;
    logic     mem_ready_i;
    logic     mem_resp_v_i;
    rvga_word mem_data_i;

    modport master (
        output mem_req_v_o,
        output mem_addr_o,
        input  mem_ready_i,
        input  mem_resp_v_i,
        input  mem_data_i
    );

    modport slave (
        input  mem_req_v_o,
        input  mem_addr_o,
        output mem_ready_i,
        output mem_resp_v_i,
        output mem_data_i
    );

endinterface

// File: rtl/imem_resp_line_buf.sv
// Single-line instruction buffer: data words, line tag, valid bit and hit compare.
module imem_line_buf
    import rvga_types::*;
#(
    parameter int LINE_WORDS = 4,
    parameter int IDX_W      = $clog2(LINE_WORDS),
    parameter int TAG_W      = 32 - IDX_W - 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             we,
    input  logic [IDX_W-1:0] widx,
    input  rvga_word         wdata,
    input  logic             set_valid,
    input  logic [TAG_W-1:0] wtag,
    input  logic             inval,
    input  logic [IDX_W-1:0] ridx,
    input  logic [TAG_W-1:0] rtag,
    output rvga_word         rdata,
    output logic             hit
);

    rvga_word         buf_r [LINE_WORDS];
    logic [TAG_W-1:0] tag_r;
    logic             valid_r;

    // Refill beats land in the data array; contents only matter once valid_r is set.
    always_ff @(posedge clk_i) begin
        if (we) begin
            buf_r[widx] <= wdata;
        end
    end

    // Invalidate has priority so a flush coinciding with the last beat leaves the line invalid.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_r <= 1'b0;
            tag_r   <= '0;
        end else if (inval) begin
            valid_r <= 1'b0;
        end else if (set_valid) begin
            valid_r <= 1'b1;
            tag_r   <= wtag;
        end
    end

    assign rdata = buf_r[ridx];
    assign hit   = valid_r && (tag_r == rtag);

endmodule

// File: rtl/imem_resp.sv
// Instruction-memory responder: combinational hits from a one-line buffer,
// stall-and-refill over the backing-memory bus on a miss.
// Optional build macro IMEM_RESP_MISALIGN_CHECK_EN: misaligned fetches in IDLE
// return NOP_WORD without stalling and set the sticky err_o flag.
//
// state | meaning
// IDLE  | serving hits; a miss latches the line base and requests it
// REQ   | mem_req_v_o held with base_r until the memory accepts
// FILL  | collecting LINE_WORDS response beats into the line buffer
module imem_resp
    import rvga_types::*;
#(
    parameter int       LINE_WORDS = 4,
    parameter rvga_word NOP_WORD   = RVGA_NOP
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  rvga_word    imem_addr_i,
    output rvga_word    imem_data_o,
    output logic        stall_o,
    input  logic        flush_i,
    imem_resp_if.master mem,
    output logic        err_o
);

    localparam int IDX_W = $clog2(LINE_WORDS);
    localparam int OFS   = IDX_W + 2;
    localparam int TAG_W = 32 - OFS;

    imem_resp_state_e state_r;
    rvga_word         base_r;
    logic [IDX_W-1:0] beat_r;
    logic             flush_seen;

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    rvga_word         line_data;
    logic             buf_hit;
    logic             hit;
    logic             misalign;
    logic             miss;
    logic             beat_v;
    logic             last_beat;

    assign idx = imem_addr_i[OFS-1:2];
    assign tag = imem_addr_i[31:OFS];

`ifdef IMEM_RESP_MISALIGN_CHECK_EN
    logic err_r;

    assign misalign = (state_r == IDLE) && (imem_addr_i[1:0] != 2'b00);

    // Sticky until reset: records that the fetch stage ever presented a misaligned PC.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_r <= 1'b0;
        end else if (misalign) begin
            err_r <= 1'b1;
        end
    end

    assign err_o = err_r;
`else
    logic unused_addr_lsb;

    assign unused_addr_lsb = ^imem_addr_i[1:0];
    assign misalign        = 1'b0;
    assign err_o           = 1'b0;
`endif

    // Hits are only honoured in IDLE: during REQ/FILL the buffer is being overwritten.
    assign hit       = buf_hit && (state_r == IDLE);
    assign miss      = (state_r == IDLE) && !hit && !misalign;
    assign beat_v    = (state_r == FILL) && mem.mem_resp_v_i;
    assign last_beat = beat_v && (beat_r == {IDX_W{1'b1}});

    assign imem_data_o = misalign ? NOP_WORD : (hit ? line_data : '0);
    assign stall_o     = !(hit || misalign);

    assign mem.mem_req_v_o = (state_r == REQ);
    assign mem.mem_addr_o  = base_r;

    // Miss handling: latch line base, hold the request, then count in the refill beats.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r    <= IDLE;
            base_r     <= '0;
            beat_r     <= '0;
            flush_seen <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (miss) begin
                        base_r  <= {tag, {OFS{1'b0}}};
                        state_r <= REQ;
                    end
                end
                REQ: begin
                    if (mem.mem_ready_i) begin
                        beat_r     <= '0;
                        flush_seen <= 1'b0;
                        state_r    <= FILL;
                    end
                end
                FILL: begin
                    if (flush_i) begin
                        flush_seen <= 1'b1;
                    end
                    if (beat_v) begin
                        beat_r <= beat_r + 1'b1;
                        if (last_beat) begin
                            flush_seen <= 1'b0;
                            state_r    <= IDLE;
                        end
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    imem_line_buf #(
        .LINE_WORDS (LINE_WORDS)
    ) u_line_buf (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .we        (beat_v),
        .widx      (beat_r),
        .wdata     (mem.mem_data_i),
        .set_valid (last_beat && !flush_seen && !flush_i),
        .wtag      (base_r[31:OFS]),
        .inval     (flush_i || (last_beat && flush_seen)),
        .ridx      (idx),
        .rtag      (tag),
        .rdata     (line_data),
        .hit       (buf_hit)
    );

endmodule
